fb_scanout: RTL
===============

# fb_scanout

Read-side counterpart of the Chip-8 blitter. It fetches one playfield line from the 16-bit-word framebuffer into a ping-pong line buffer, then shifts it out one pixel per strobe to the video path. The blitter writes the framebuffer through one RAM port; this block owns the second, read-only port. It uses the same word layout as the blitter: 16 pixels per word, MSB leftmost.

## Interface
No parameters. Geometry is fixed: lores 64x32 (4 words/line, 128 words); hires 128x64 (8 words/line, 512 words).
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- hires  in  1  resolution mode, sampled on fetch_start
- fetch_start  in  1  one-cycle pulse: fetch line fetch_line into back buffer
- fetch_line  in  6  playfield line; bit 5 ignored in lores
- line_go  in  1  one-cycle pulse: swap buffers, restart pixel counter
- pix_next  in  1  advance to next pixel
- underrun_clr  in  1  clears underrun flag
- buf_out  in  16  framebuffer read data
- buf_addr  out  9  framebuffer read address (registered)
- buf_enable  out  1  read enable (registered)
- busy  out  1  fetch in progress
- fetch_done  out  1  one-cycle pulse when last word captured
- pixel  out  1  current pixel (registered)
- line_end  out  1  high once all pixels of the front line are consumed
- underrun  out  1  sticky: line_go arrived while busy

## Operation
- Fetch FSM has three states: IDLE, ISSUE, DRAIN.
- IDLE:
  - On fetch_start: latch hires into back_hires, set word counter to 0, busy=1, buf_enable=1, go to ISSUE.
- ISSUE:
  - Issue one address per cycle. Address is {fetch_line[5:0],w[2:0]} for hires, {fetch_line[4:0],w[1:0]} for lores, zero-extended to 9 bits.
  - After the last word (3 or 7): buf_enable=0, go to DRAIN.
- Capture:
  - A 2-stage valid/index pipeline tracks each read.
  - The word is written into back[idx] when its stage-2 valid is set.
- DRAIN:
  - Wait until the pipeline is empty, then pulse fetch_done, busy=0, back_valid=1, go to IDLE.
- fetch_start while busy is ignored.
- line_go while not busy:
  - Swap front/back and copy back_valid into front_valid.
  - Set front_hires from back_hires, pixel counter to 0, line_end=0.
  - Clear back_valid.
- line_go while busy:
  - No swap. underrun=1 (sticky); front_valid=0, so the line outputs zeros.
  - Fetch completes normally.
- line_go and fetch_start in the same cycle: swap first, then fetch into the new back buffer (the old front).
- Pixel path:
  - pixel = front_valid & front[cnt[6:4]][15-cnt[3:0]].
  - On pix_next, cnt increments until it reaches the limit (63 lores / 127 hires).
  - pix_next at the limit sets line_end=1 and pixel=0; cnt holds.
  - Further pix_next has no effect until line_go.
- underrun_clr clears underrun. If underrun_clr and a set event coincide, set wins.

## Timing
- Reset values: buf_addr=0, buf_enable=0, busy=0, fetch_done=0, pixel=0, line_end=0, underrun=0. front_valid and back_valid are 0; buffer contents are undefined.
- RAM read latency: buf_out holds data for an address two rising edges after buf_addr/buf_enable are registered, matching the blitter's wait-then-use timing.
- Fetch_start accepted at edge T:
  - First address registered at T.
  - Addresses follow on consecutive edges.
  - Last address at T+3 (lores) / T+7 (hires).
  - fetch_done pulses at T+6 / T+10; busy falls on the same edge.
- Swap and pixel path:
  - line_go at edge S: pixel for cnt=0 is valid after S+1.
  - Each pix_next at edge P: new pixel valid after P+1.
- Reset mid-fetch: aborts immediately. No fetch_done; all valid flags are cleared.
- A hires toggle mid-fetch has no effect until the next fetch_start.

## Structure
- Constants belong in the shared blitter header:
  - words per line (4/8)
  - pixels per line (64/128)
  - address composition widths
- Natural sub-module: fb_line_buffer, a two-bank 8x16 register array.
  - Ports: bank select, write index/data/enable, read word index.
  - Swap logic and the fetch FSM stay in the top.

## Test plan
- Lores fetch, line 5, with the RAM model filled so word value = address: addresses 20..23 issued on consecutive cycles, fetch_done pulses 6 cycles after the accepted fetch_start, back[0..3]=20..23.
- Hires fetch, line 63, RAM word 511=0x8001: line_go then 128 pix_next. Pixel high at indices 112 and 127 only; line_end=1 after the 128th strobe.
- line_go 2 cycles into a hires fetch: underrun=1, pixel stays 0 for the line, fetch_done still pulses. A second line_go swaps in the fetched data; underrun_clr then clears the flag.
- Simultaneous line_go and fetch_start with back_valid=1: the front shows the previously fetched line while the new fetch fills the other bank, with no corruption of the front data.
- Assert reset_n low at the midpoint of a fetch: buf_enable=0 and busy=0 immediately, no fetch_done, and pixel=0 after line_go until a new fetch completes.

Source files
------------

// File: rtl/fb_scanout_pkg.sv
// rtl/fb_scanout_pkg.sv - geometry constants, FSM states and address helper for fb_scanout
package fb_scanout_pkg;

  localparam int ADDR_W = 9;
  localparam int WORD_W = 16;
  localparam int LINE_W = 6;
  localparam int IDX_W  = 3;
  localparam int CNT_W  = 7;

  // Words per line and pixels per line for each resolution
  localparam int LORES_WORDS = 4;
  localparam int HIRES_WORDS = 8;
  localparam int LORES_PIXELS = 64;
  localparam int HIRES_PIXELS = 128;

  localparam logic [IDX_W-1:0] LORES_LAST_WORD = 3'(LORES_WORDS - 1);
  localparam logic [IDX_W-1:0] HIRES_LAST_WORD = 3'(HIRES_WORDS - 1);
  localparam logic [CNT_W-1:0] LORES_LAST_PIX  = 7'(LORES_PIXELS - 1);
  localparam logic [CNT_W-1:0] HIRES_LAST_PIX  = 7'(HIRES_PIXELS - 1);

  // Fetch FSM states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Framebuffer word address: line concatenated with word index; lores drops line bit 5
  function automatic logic [ADDR_W-1:0] fb_word_addr(
    input logic              hires,
    input logic [LINE_W-1:0] line,
    input logic [IDX_W-1:0]  w
  );
    if (hires) begin
      return {line, w};
    end
    return {2'b00, line[4:0], w[1:0]};
  endfunction

endpackage

// File: rtl/fb_line_buffer.sv
// rtl/fb_line_buffer.sv - two-bank 8x16 line buffer, one write port and one async read port
module fb_line_buffer
  import fb_scanout_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic              i_wr_bank,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [WORD_W-1:0] i_wr_data,
  input  logic              i_rd_bank,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic [WORD_W-1:0] o_rd_data
);

  logic [WORD_W-1:0] r_mem [0:1][0:7];

  // Storage only; contents are qualified by the valid flags in the top, so no reset
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_bank][i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_bank][i_rd_idx];

endmodule

// File: rtl/fb_scanout.sv
// rtl/fb_scanout.sv - fetches one framebuffer line into a ping-pong buffer and shifts it out per pixel
module fb_scanout
  import fb_scanout_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_hires,
  input  logic              i_fetch_start,
  input  logic [LINE_W-1:0] i_fetch_line,
  input  logic              i_line_go,
  input  logic              i_pix_next,
  input  logic              i_underrun_clr,
  input  logic [WORD_W-1:0] i_buf_out,
  output logic [ADDR_W-1:0] o_buf_addr,
  output logic              o_buf_enable,
  output logic              o_busy,
  output logic              o_fetch_done,
  output logic              o_pixel,
  output logic              o_line_end,
  output logic              o_underrun
);

  logic [1:0]        r_state;
  logic              r_back_hires;
  logic              r_front_hires;
  logic [LINE_W-1:0] r_line;
  logic [IDX_W-1:0]  r_w;
  logic [ADDR_W-1:0] r_buf_addr;
  logic              r_buf_enable;
  logic              r_busy;
  logic              r_fetch_done;
  logic              r_back_valid;
  logic              r_s1_valid;
  logic [IDX_W-1:0]  r_s1_idx;
  logic              r_s2_valid;
  logic [IDX_W-1:0]  r_s2_idx;
  logic              r_front_bank;
  logic              r_front_valid;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_line_end;
  logic              r_pixel;
  logic              r_underrun;

  logic [IDX_W-1:0]  w_last_word;
  logic [CNT_W-1:0]  w_last_pix;
  logic              w_fetch_fin;
  logic              w_back_bank;
  logic [WORD_W-1:0] w_rd_data;

  assign w_last_word = r_back_hires ? HIRES_LAST_WORD : LORES_LAST_WORD;
  assign w_last_pix  = r_front_hires ? HIRES_LAST_PIX : LORES_LAST_PIX;
  // Last capture happens when stage 2 holds a word and nothing follows it
  assign w_fetch_fin = (r_state == ST_DRAIN) && r_s2_valid && !r_s1_valid;
  assign w_back_bank = ~r_front_bank;

  fb_line_buffer u_line_buffer (
    .i_clk     (i_clk),
    .i_wr_en   (r_s2_valid),
    .i_wr_bank (w_back_bank),
    .i_wr_idx  (r_s2_idx),
    .i_wr_data (i_buf_out),
    .i_rd_bank (r_front_bank),
    .i_rd_idx  (r_cnt[6:4]),
    .o_rd_data (w_rd_data)
  );

  // Fetch FSM: issue one address per cycle, then wait for the read pipeline to drain
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= ST_IDLE;
      r_back_hires <= 1'b0;
      r_line       <= '0;
      r_w          <= '0;
      r_buf_addr   <= '0;
      r_buf_enable <= 1'b0;
      r_busy       <= 1'b0;
      r_fetch_done <= 1'b0;
      r_back_valid <= 1'b0;
    end else begin
      r_fetch_done <= 1'b0;
      if (w_fetch_fin) begin
        r_back_valid <= 1'b1;
      end else if ((i_line_go || i_fetch_start) && !r_busy) begin
        r_back_valid <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (i_fetch_start) begin
            r_back_hires <= i_hires;
            r_line       <= i_fetch_line;
            r_w          <= '0;
            r_buf_addr   <= fb_word_addr(i_hires, i_fetch_line, 3'd0);
            r_buf_enable <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (r_w == w_last_word) begin
            r_buf_enable <= 1'b0;
            r_state      <= ST_DRAIN;
          end else begin
            r_w        <= r_w + 3'd1;
            r_buf_addr <= fb_word_addr(r_back_hires, r_line, r_w + 3'd1);
          end
        end
        ST_DRAIN: begin
          if (w_fetch_fin) begin
            r_fetch_done <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Two-stage valid/index pipeline matching the RAM read latency
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_idx   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_idx   <= '0;
    end else begin
      r_s1_valid <= r_buf_enable;
      r_s1_idx   <= r_w;
      r_s2_valid <= r_s1_valid;
      r_s2_idx   <= r_s1_idx;
    end
  end

  // Buffer swap on line_go and pixel counter; a line_go during a fetch blanks the line instead
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_front_bank  <= 1'b0;
      r_front_valid <= 1'b0;
      r_front_hires <= 1'b0;
      r_cnt         <= '0;
      r_line_end    <= 1'b0;
    end else if (i_line_go) begin
      r_cnt      <= '0;
      r_line_end <= 1'b0;
      if (r_busy) begin
        r_front_valid <= 1'b0;
      end else begin
        r_front_bank  <= ~r_front_bank;
        r_front_valid <= r_back_valid;
        r_front_hires <= r_back_hires;
      end
    end else if (i_pix_next && !r_line_end) begin
      if (r_cnt == w_last_pix) begin
        r_line_end <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 7'd1;
      end
    end
  end

  // Registered pixel: MSB of each word is leftmost, blank once the line is consumed
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pixel <= 1'b0;
    end else begin
      r_pixel <= r_front_valid && !r_line_end && w_rd_data[~r_cnt[3:0]];
    end
  end

  // Sticky underrun flag; a new underrun wins over a clear in the same cycle
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_underrun <= 1'b0;
    end else if (i_line_go && r_busy) begin
      r_underrun <= 1'b1;
    end else if (i_underrun_clr) begin
      r_underrun <= 1'b0;
    end
  end

  assign o_buf_addr   = r_buf_addr;
  assign o_buf_enable = r_buf_enable;
  assign o_busy       = r_busy;
  assign o_fetch_done = r_fetch_done;
  assign o_pixel      = r_pixel;
  assign o_line_end   = r_line_end;
  assign o_underrun   = r_underrun;

endmodule
